// File: rtl/half_duplex_pad_pkg.sv
// Shared types for the half-duplex pad controller: FSM states, bus direction
// and a small helper for sizing the cycle counter.
package half_duplex_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        DRIVE,
        SETTLE,
        RESP
    } state_t;

    typedef enum logic {
        DIR_READ,
        DIR_WRITE
    } dir_t;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/half_duplex_pad_ctrl_sync.sv
// Multi-stage synchroniser that brings the asynchronous pad input bus into
// the core clock domain.
module pad_in_sync #(
    parameter int Width      = 32,
    parameter int SyncStages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] stage [SyncStages];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SyncStages; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SyncStages; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[SyncStages-1];

endmodule

// File: rtl/half_duplex_pad_ctrl.sv
// Core-side controller for a bank of bidirectional pads: turns single-beat
// read/write requests into drive/sample sequences with bus turnaround.
module half_duplex_pad_ctrl
    import half_duplex_pad_pkg::*;
#(
    parameter int Width       = 32,
    parameter int TurnCycles  = 1,
    parameter int DriveCycles = 2,
    parameter int SyncStages  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_mask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic [Width-1:0] pad_out_o,
    output logic [Width-1:0] pad_oe_o,
    input  logic [Width-1:0] pad_in_i
);

    localparam int CntW = $clog2(max_of3(TurnCycles, DriveCycles, SyncStages)) + 1;
    localparam logic [CntW-1:0] TurnLoad   = CntW'(TurnCycles - 1);
    localparam logic [CntW-1:0] DriveLoad  = CntW'(DriveCycles - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SyncStages - 1);

    state_t           state;
    dir_t             last_dir;
    dir_t             req_dir;
    logic [CntW-1:0]  cnt;
    logic             wr_q;
    logic [Width-1:0] wdata_q;
    logic [Width-1:0] mask_q;
    logic [Width-1:0] sync_out;

    pad_in_sync #(
        .Width      (Width),
        .SyncStages (SyncStages)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (pad_in_i),
        .q   (sync_out)
    );

    assign req_dir = req_write_i ? DIR_WRITE : DIR_READ;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_dir    <= DIR_READ;
            cnt         <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            mask_q      <= '0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            pad_oe_o    <= '0;
            pad_out_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        wr_q        <= req_write_i;
                        wdata_q     <= req_wdata_i;
                        mask_q      <= req_mask_i;
                        if (req_dir != last_dir) begin
                            // Release every bit before the bus changes direction.
                            state     <= TURN;
                            cnt       <= TurnLoad;
                            pad_oe_o  <= '0;
                            pad_out_o <= '0;
                        end else if (req_write_i) begin
                            state     <= DRIVE;
                            cnt       <= DriveLoad;
                            pad_oe_o  <= req_mask_i;
                            pad_out_o <= req_wdata_i & req_mask_i;
                        end else begin
                            state    <= SETTLE;
                            cnt      <= SettleLoad;
                            pad_oe_o <= '0;
                        end
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        last_dir <= wr_q ? DIR_WRITE : DIR_READ;
                        if (wr_q) begin
                            state     <= DRIVE;
                            cnt       <= DriveLoad;
                            pad_oe_o  <= mask_q;
                            pad_out_o <= wdata_q & mask_q;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SettleLoad;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    // Pads stay parked at the driven value after the write completes.
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= sync_out;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_duplex_pad_ctrl.sv
// Directed bench for half_duplex_pad_ctrl: table of single transactions plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_half_duplex_pad_ctrl;

    localparam int W = 8;

    typedef struct {
        logic         wr;
        logic [W-1:0] wdata;
        logic [W-1:0] mask;
        logic [W-1:0] pin;
        int           lat;
        logic [W-1:0] oe1;
        logic [W-1:0] oe2;
        logic         chk_out1;
        logic [W-1:0] exp_out;
        logic [W-1:0] oe_resp;
        logic [W-1:0] rdata;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [W-1:0] req_wdata = '0;
    logic [W-1:0] req_mask = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_rdata;
    logic [W-1:0] pad_out;
    logic [W-1:0] pad_oe;
    logic [W-1:0] pad_in = '0;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [8];
    vec_t rst_vec;

    half_duplex_pad_ctrl #(
        .Width       (W),
        .TurnCycles  (1),
        .DriveCycles (2),
        .SyncStages  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_mask_i  (req_mask),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .pad_out_o   (pad_out),
        .pad_oe_o    (pad_oe),
        .pad_in_i    (pad_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        int cyc;
        @(negedge clk);
        pad_in    = v.pin;
        req_write = v.wr;
        req_wdata = v.wdata;
        req_mask  = v.mask;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready before accept"}, 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 1) begin
                chk({tag, " oe cycle1"}, 32'(pad_oe), 32'(v.oe1));
                chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
                if (v.chk_out1) chk({tag, " out cycle1"}, 32'(pad_out), 32'(v.exp_out));
            end
            if (cyc == 2) begin
                chk({tag, " oe cycle2"}, 32'(pad_oe), 32'(v.oe2));
                if (v.wr) chk({tag, " out cycle2"}, 32'(pad_out), 32'(v.exp_out));
            end
            if (rsp_valid) break;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(cyc), 32'(v.lat));
        chk({tag, " rdata"}, 32'(rsp_rdata), 32'(v.rdata));
        chk({tag, " oe in resp"}, 32'(pad_oe), 32'(v.oe_resp));
        if (v.wr) chk({tag, " out in resp"}, 32'(pad_out), 32'(v.exp_out));
        @(negedge clk);
        chk({tag, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready after handshake"}, 32'(req_ready), 32'd1);
        chk({tag, " oe parked"}, 32'(pad_oe), 32'(v.oe_resp));
        if (v.wr) chk({tag, " out parked"}, 32'(pad_out), 32'(v.exp_out));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //            wr    wdata  mask   pin    lat oe1    oe2    c1    out    oe_rsp rdata
        vecs[0] = '{1'b0, 8'h00, 8'h00, 8'hA5, 3, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 8'h3C, 8'hFF, 8'h00, 4, 8'h00, 8'hFF, 1'b0, 8'h3C, 8'hFF, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h5A, 4, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h5A};
        vecs[3] = '{1'b1, 8'hFF, 8'h0F, 8'h00, 4, 8'h00, 8'h0F, 1'b0, 8'h0F, 8'h0F, 8'h00};
        vecs[4] = '{1'b1, 8'h00, 8'hF0, 8'h00, 3, 8'hF0, 8'hF0, 1'b1, 8'h00, 8'hF0, 8'h00};
        vecs[5] = '{1'b1, 8'hA5, 8'hFF, 8'h00, 3, 8'hFF, 8'hFF, 1'b1, 8'hA5, 8'hFF, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 8'hFF, 8'hC3, 4, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'hC3};
        vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h3C, 3, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h3C};
        rst_vec = '{1'b1, 8'h33, 8'hFF, 8'h00, 4, 8'h00, 8'hFF, 1'b0, 8'h33, 8'hFF, 8'h00};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", 32'(rsp_rdata), 32'd0);
        chk("reset oe", 32'(pad_oe), 32'd0);
        chk("reset out", 32'(pad_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Response backpressure with a pending request behind it
        @(negedge clk);
        pad_in    = 8'h77;
        req_write = 1'b0;
        req_mask  = 8'h00;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b1;
        req_wdata = 8'h11;
        req_mask  = 8'hFF;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp rsp_valid rises", 32'(rsp_valid), 32'd1);
        pad_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp hold valid %0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold rdata %0d", i), 32'(rsp_rdata), 32'h77);
            chk($sformatf("bp req_ready %0d", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp rsp_valid cleared", 32'(rsp_valid), 32'd0);
        chk("bp req_ready after handshake", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp pending accepted", 32'(req_ready), 32'd0);
        chk("bp pending turn oe", 32'(pad_oe), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp pending write resp", 32'(rsp_valid), 32'd1);
        chk("bp pending write oe", 32'(pad_oe), 32'hFF);
        chk("bp pending write out", 32'(pad_out), 32'h11);
        @(negedge clk);

        // Reset during the first DRIVE cycle of a same-direction write
        req_write = 1'b1;
        req_wdata = 8'h22;
        req_mask  = 8'hFF;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst-mid drive oe", 32'(pad_oe), 32'hFF);
        chk("rst-mid drive out", 32'(pad_out), 32'h22);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-mid oe released", 32'(pad_oe), 32'd0);
        chk("rst-mid out cleared", 32'(pad_out), 32'd0);
        chk("rst-mid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst-mid req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        run_txn(rst_vec, "post-reset write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/half_duplex_pad_ctrl.md
Name: half_duplex_pad_ctrl

Overview:
- Core-side controller for a bank of bidirectional tristate pads. It produces the per-bit output data and output-enable, and takes the pad input value back from the bank.
- Turns single-beat read/write requests into pad transactions with direction turnaround, drive hold, input synchronisation and a valid/ready response.
- Sits between a register/peripheral front-end and the FPGA pad buffer bank.

Parameters:
- Width, 32, number of pad bits.
- TurnCycles, 1, cycles (>=1) with all bits released on any direction change.
- DriveCycles, 2, cycles (>=1) a write holds data on the pads before responding.
- SyncStages, 2, flop stages (>=2) on pad_in_i.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_write_i  in  1  1=write (drive), 0=read (sample).
- req_wdata_i  in  Width  write data.
- req_mask_i  in  Width  per-bit drive enable for writes; ignored on reads.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  Width  read data; 0 for writes.
- pad_out_o  out  Width  to pad buffer data input.
- pad_oe_o  out  Width  to pad buffer enable; 1 = bit driven.
- pad_in_i  in  Width  from pad buffer output; asynchronous.

Behaviour:
- Reset:
  - state=IDLE, last_dir=READ.
  - pad_oe_o=0, pad_out_o=0.
  - req_ready_o=0 during reset.
  - rsp_valid_o=0, rsp_rdata_o=0.
  - Sync chain cleared to 0.
- Reset mid-transaction aborts it. No response is issued, and pads are released on the cycle after rst_i is sampled high.
- FSM states: IDLE, TURN, DRIVE, SETTLE, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On req_valid_i && req_ready_o, latch write, wdata, mask.
  - If the request direction != last_dir, go to TURN. Otherwise go to DRIVE (write) or SETTLE (read).
- TURN:
  - pad_oe_o=0 for exactly TurnCycles cycles.
  - Then go to DRIVE or SETTLE, and set last_dir to the new direction.
- DRIVE:
  - pad_oe_o=mask, pad_out_o=wdata & mask, for DriveCycles cycles.
  - Then go to RESP with rsp_rdata_o=0.
- Bus parking:
  - After a write, pad_oe_o/pad_out_o keep the last driven value through RESP and IDLE, until a read's TURN or reset.
  - A write directly after a write goes straight to DRIVE; enable and data update on the first DRIVE cycle.
- SETTLE:
  - pad_oe_o=0 for SyncStages cycles.
  - On the last cycle, register the final sync stage into rsp_rdata_o, then go to RESP.
- RESP:
  - rsp_valid_o=1, with rsp_rdata_o held stable, until rsp_ready_i.
  - Return to IDLE on the cycle after the handshake.
  - rsp_valid_o does not depend combinationally on rsp_ready_i.
- Latency (cycle 0 = request accept; figures assume rsp_ready_i=1):
  - Write, same direction: rsp_valid_o rises at cycle DriveCycles+1.
  - Read, same direction: rsp_valid_o rises at cycle SyncStages+1.
  - A direction change adds TurnCycles.
- Read data contract: rsp_rdata_o equals pad_in_i whenever pad_in_i was stable for the SyncStages+1 cycles before the response. Otherwise each bit is an old or new value, never X.
- Counters sized by $clog2 of the largest of the cycle parameters, plus 1. Counters reload on each state entry and never wrap.
- No outstanding-request pipelining: one transaction in flight at a time.

Decomposition:
- Package half_duplex_pad_pkg:
  - state enum {IDLE, TURN, DRIVE, SETTLE, RESP}.
  - dir enum {DIR_READ, DIR_WRITE}.
- Sub-module pad_in_sync:
  - Width-wide, SyncStages-deep flop chain.
  - Synchronous active-high reset to 0.
  - Instantiated once on pad_in_i.

Test Plan:
Bench config: Width=8, TurnCycles=1, DriveCycles=2, SyncStages=2.
1. Read after reset, pad_in_i=0xA5 held -> no TURN; pad_oe_o=0x00 throughout; rsp_valid_o at cycle 3; rdata=0xA5.
2. Write wdata=0x3C, mask=0xFF after reset -> TURN 1 cycle with oe=0x00; oe=0xFF and out=0x3C from cycle 2; rsp_valid_o at cycle 4, rdata=0x00; oe stays 0xFF/out 0x3C in IDLE.
3. Write 0x3C then read with pad_in_i=0x5A -> oe drops to 0x00 the cycle after accept; rsp_valid_o 4 cycles after accept; rdata=0x5A.
4. Write wdata=0xFF, mask=0x0F -> oe=0x0F, out=0x0F; write-after-write wdata=0x00, mask=0xF0 -> no TURN; oe=0xF0, out=0x00 on the first DRIVE cycle.
5. Response backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rdata stable; req_ready_o=0; a pending req_valid_i is not accepted until the cycle after the handshake.
6. rst_i in DRIVE cycle 1 -> next cycle oe=0x00, out=0x00, rsp_valid_o=0; a following write takes the TURN path again (last_dir=READ).
